microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Parametrised, writable-control-store microprogram sequencer for the processor control path.
//  Holds the microprogram RAM and an opcode dispatch table, and steps a uPC.
//  Drives a registered control word to ALU, mux and memory controls.
//  Supports opcode dispatch, conditional branch with selectable flag and polarity, stall, halt, restart.
// PARAMETERS
//  CW_WIDTH     41  control-word bits delivered to the datapath
//  UADDR_WIDTH  6   uPC width; control store depth = 2**UADDR_WIDTH
//  OPC_WIDTH    4   opcode width; dispatch table depth = 2**OPC_WIDTH
//  CSEL_W       1   condition-select width; NUM_COND = 2**CSEL_W
//  START_ADDR   0   uPC loaded on start
//  Derived: W = CW_WIDTH+2+1+CSEL_W+UADDR_WIDTH (defaults: 51)
// PORTS
//  clock     in   1            rising-edge clock
//  reset_n   in   1            asynchronous, active-low reset
//  start     in   1            pulse: IDLE/HALT -> RUN at START_ADDR
//  halt_req  in   1            force HALT (END condition from datapath)
//  stall     in   1            hold uPC and ctrl for this cycle
//  opcode    in   OPC_WIDTH    instruction register opcode, used on DISPATCH
//  cond      in   NUM_COND     status flags (bit0 = Z, ...)
//  wr_en     in   1            store write strobe
//  wr_sel    in   1            0 = microprogram RAM, 1 = dispatch table
//  wr_addr   in   UADDR_WIDTH  write address (low OPC_WIDTH bits used when wr_sel=1)
//  wr_data   in   W            write data (low UADDR_WIDTH bits used when wr_sel=1)
//  ctrl      out  CW_WIDTH     registered control word
//  upc       out  UADDR_WIDTH  current microaddress
//  busy      out  1            1 while in RUN
//  halted    out  1            1 while in HALT
//  wr_err    out  1            one-cycle pulse: write attempted while in RUN, write dropped
// BEHAVIOUR
//  Microword layout: [W-1 -: CW_WIDTH]=ctrl, then seq[1:0], inv, csel[CSEL_W-1:0], next[UADDR_WIDTH-1:0] (LSBs).
//  Reset (async, reset_n=0): state=IDLE, upc=START_ADDR, ctrl=0, busy=0, halted=0, wr_err=0.
//  Reset does not clear the stores; contents are retained across reset.
//  FSM states:
//   IDLE: start=1 -> RUN.
//   RUN: each non-stalled edge does ctrl <= word[upc].ctrl and upc <= next_upc (below).
//   HALT: start=1 -> RUN.
//  On entry to RUN: upc=START_ADDR and ctrl=0. The first word's ctrl appears one edge later.
//  Latency: ctrl always reflects the word fetched at the previous upc (1 cycle).
//  Control store read is asynchronous; the table lookup is combinational.
//  next_upc by seq:
//   00 JUMP:     next
//   01 DISPATCH: dtab[opcode]
//   10 BRANCH:   (cond[csel]^inv) ? next : upc+1 (modulo 2**UADDR_WIDTH, wraps max->0)
//   11 END:      go to HALT; ctrl <= word.ctrl for this final cycle, upc holds
//  Priority in RUN, highest first: halt_req, then stall, then sequencing.
//   halt_req -> HALT next edge, ctrl <= 0, upc holds.
//   stall -> upc and ctrl hold; the word's effects are not repeated.
//  In HALT or IDLE: ctrl=0 from the first non-RUN cycle after END's final cycle.
//  start and halt_req together in IDLE/HALT: halt_req wins; stay or enter HALT.
//  start during RUN is ignored.
//  Writes are accepted only in IDLE/HALT and commit on the edge.
//  A write in RUN is dropped and pulses wr_err for one cycle.
//  A write and start on the same edge: the write commits and start is honoured.
//  The write is visible to the first fetch.
//  busy = (state==RUN); halted = (state==HALT). Both registered, mutually exclusive.
//  Reset asserted mid-microprogram: immediate return to reset values; no partial ctrl is held.
// TESTING
//  T1: load word0 = {ctrl=41'h1, JUMP, next=1}, word1 = {ctrl=41'h2, END}; start ->
//      ctrl 1 then 2 on consecutive edges; halted=1 with ctrl=0 on the following edge.
//  T2: dtab[4'h7]=6'd24, word0 = DISPATCH; opcode=7, start -> upc=24 one edge after upc=0.
//  T3: word5 = BRANCH csel=0 inv=1 next=38; Z=0 -> upc=38; Z=1 -> upc=6;
//      upc=63 with a failed branch -> upc wraps to 0.
//  T4: stall for 3 cycles mid-run -> upc/ctrl frozen for 3 cycles; the sequence then resumes unchanged.
//      halt_req with stall asserted -> HALT.
//  T5: wr_en while busy -> store unchanged, wr_err high for 1 cycle.
//      reset_n low mid-run -> ctrl=0, upc=0 asynchronously; the program reruns identically after start.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Writable-control-store microprogram sequencer: uPC, microprogram RAM, opcode dispatch table, registered ctrl.
// Latency: ctrl shows the word fetched at the previous upc (1 cycle); stall freezes upc/ctrl, halt_req wins over stall.
module microcode_sequencer #(
  parameter  int CW_WIDTH    = 41,
  parameter  int UADDR_WIDTH = 6,
  parameter  int OPC_WIDTH   = 4,
  parameter  int CSEL_W      = 1,
  parameter  int START_ADDR  = 0,
  localparam int NUM_COND    = 2**CSEL_W,
  localparam int W           = CW_WIDTH + 2 + 1 + CSEL_W + UADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   stall,
  input  logic [OPC_WIDTH-1:0]   opcode,
  input  logic [NUM_COND-1:0]    cond,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [UADDR_WIDTH-1:0] wr_addr,
  input  logic [W-1:0]           wr_data,
  output logic [CW_WIDTH-1:0]    ctrl,
  output logic [UADDR_WIDTH-1:0] upc,
  output logic                   busy,
  output logic                   halted,
  output logic                   wr_err
);

  localparam logic [UADDR_WIDTH-1:0] START_UPC = UADDR_WIDTH'(START_ADDR);
  localparam logic [UADDR_WIDTH-1:0] UPC_ONE   = {{(UADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SEQ_JUMP     = 2'b00,
    SEQ_DISPATCH = 2'b01,
    SEQ_BRANCH   = 2'b10,
    SEQ_END      = 2'b11
  } seq_t;

  typedef struct packed {
    logic [CW_WIDTH-1:0]    ctrl;
    seq_t                   seq;
    logic                   inv;
    logic [CSEL_W-1:0]      csel;
    logic [UADDR_WIDTH-1:0] nxt;
  } uword_t;

  // Stores have no reset so their contents survive reset_n.
  logic [W-1:0]           ustore [2**UADDR_WIDTH];
  logic [UADDR_WIDTH-1:0] dtab   [2**OPC_WIDTH];

  state_t                 state_q, state_d;
  logic [UADDR_WIDTH-1:0] upc_q, upc_d;
  logic [CW_WIDTH-1:0]    ctrl_q, ctrl_d;
  logic                   wr_err_q;
  logic                   store_we;
  logic                   branch_taken;
  uword_t                 word;

  assign word         = uword_t'(ustore[upc_q]);
  assign branch_taken = cond[word.csel] ^ word.inv;
  assign store_we     = wr_en && (state_q != ST_RUN);

  always_ff @(posedge clock) begin
    if (store_we) begin
      if (wr_sel) begin
        dtab[wr_addr[OPC_WIDTH-1:0]] <= wr_data[UADDR_WIDTH-1:0];
      end else begin
        ustore[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
          ctrl_d  = '0;
        end else if (!stall) begin
          ctrl_d = word.ctrl;
          case (word.seq)
            SEQ_JUMP:     upc_d = word.nxt;
            SEQ_DISPATCH: upc_d = dtab[opcode];
            SEQ_BRANCH:   upc_d = branch_taken ? word.nxt : (upc_q + UPC_ONE);
            SEQ_END:      state_d = ST_HALT;
            default:      upc_d = upc_q;
          endcase
        end
      end
      default: begin
        // IDLE and HALT: ctrl is cleared; the END word's ctrl lasts exactly one cycle.
        ctrl_d = '0;
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (start) begin
          state_d = ST_RUN;
          upc_d   = START_UPC;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      upc_q    <= START_UPC;
      ctrl_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      upc_q    <= upc_d;
      ctrl_q   <= ctrl_d;
      wr_err_q <= wr_en && (state_q == ST_RUN);
    end
  end

  assign ctrl   = ctrl_q;
  assign upc    = upc_q;
  assign busy   = (state_q == ST_RUN);
  assign halted = (state_q == ST_HALT);
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: stimulus pushes per-cycle expectations, a monitor pops and compares.
// Clock-based entries are checked at negedge+1; reset-fall entries are checked 1 time unit after reset_n drops.
module tb_microcode_sequencer;

  localparam logic [1:0] JMP = 2'b00;
  localparam logic [1:0] DSP = 2'b01;
  localparam logic [1:0] BRA = 2'b10;
  localparam logic [1:0] ENDS = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  cond = '0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [50:0] wr_data = '0;
  logic [40:0] ctrl;
  logic [5:0]  upc;
  logic        busy, halted, wr_err;

  microcode_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .halt_req(halt_req), .stall(stall),
    .opcode(opcode), .cond(cond), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .ctrl(ctrl), .upc(upc), .busy(busy), .halted(halted), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    bit          async;
    logic [40:0] ctrl;
    logic [5:0]  upc;
    logic        busy;
    logic        halted;
    logic        wr_err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [50:0] mw(input logic [40:0] c, input logic [1:0] s,
                                     input logic i, input logic cs, input logic [5:0] n);
    return {c, s, i, cs, n};
  endfunction

  task automatic compare(input exp_t x);
    logic [49:0] got, want;
    got  = {ctrl, upc, busy, halted, wr_err};
    want = {x.ctrl, x.upc, x.busy, x.halted, x.wr_err};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got ctrl=%h upc=%0d busy=%b halted=%b wr_err=%b, want ctrl=%h upc=%0d busy=%b halted=%b wr_err=%b",
               x.name, ctrl, upc, busy, halted, wr_err, x.ctrl, x.upc, x.busy, x.halted, x.wr_err);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clock or negedge reset_n);
      #1;
      while (exp_q.size() > 0 && !exp_q[0].async && exp_q[0].cyc < cyc_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                 exp_q[0].name, exp_q[0].cyc, cyc_cnt);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && (exp_q[0].async || exp_q[0].cyc == cyc_cnt)) begin
        compare(exp_q.pop_front());
      end
    end
  end

  task automatic step(input string n, input logic [40:0] c, input logic [5:0] u,
                      input logic b, input logic h, input logic e);
    exp_t x;
    x.cyc = cyc_cnt + 1; x.async = 1'b0;
    x.ctrl = c; x.upc = u; x.busy = b; x.halted = h; x.wr_err = e; x.name = n;
    exp_q.push_back(x);
    @(posedge clock);
    #2;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wr(input logic sel, input logic [5:0] a, input logic [50:0] d,
                    input logic [5:0] u, input logic h);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    step("store_write", '0, u, 1'b0, h, 1'b0);
  endtask

  task automatic rst_step(input string n);
    exp_t x;
    @(negedge clock);
    #2;
    x.cyc = cyc_cnt; x.async = 1'b1;
    x.ctrl = '0; x.upc = '0; x.busy = 1'b0; x.halted = 1'b0; x.wr_err = 1'b0; x.name = n;
    exp_q.push_back(x);
    reset_n = 1'b0;
    @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_step("reset");
    reset_n = 1'b1; step("reset_release", 0, 0, 0, 0, 0);

    // T1: two-word program, END halts after its own ctrl cycle
    wr(0, 0, mw(41'h1, JMP, 0, 0, 1), 0, 0);
    wr(0, 1, mw(41'h2, ENDS, 0, 0, 0), 0, 0);
    start = 1; step("t1_start", 0, 0, 1, 0, 0);
    step("t1_word0", 41'h1, 1, 1, 0, 0);
    step("t1_word1_end", 41'h2, 1, 0, 1, 0);
    step("t1_halted", 0, 1, 0, 1, 0);

    // T2: dispatch; word0 written on the same edge as start
    wr(1, 7, 51'd24, 1, 1);
    wr(0, 24, mw(41'h4, ENDS, 0, 0, 0), 1, 1);
    opcode = 4'h7; start = 1; wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = mw(41'h3, DSP, 0, 0, 0);
    step("t2_write_and_start", 0, 0, 1, 0, 0);
    step("t2_dispatch", 41'h3, 24, 1, 0, 0);
    step("t2_end", 41'h4, 24, 0, 1, 0);
    step("t2_halted", 0, 24, 0, 1, 0);

    // T3: inverted Z branch taken / not taken, and uPC wrap
    wr(0, 0, mw(41'h6, JMP, 0, 0, 5), 24, 1);
    wr(0, 5, mw(41'h5, BRA, 1, 0, 38), 24, 1);
    wr(0, 38, mw(41'h7, ENDS, 0, 0, 0), 24, 1);
    wr(0, 6, mw(41'h8, ENDS, 0, 0, 0), 24, 1);
    cond = 2'b00; start = 1; step("t3a_start", 0, 0, 1, 0, 0);
    step("t3a_word0", 41'h6, 5, 1, 0, 0);
    step("t3a_branch_taken", 41'h5, 38, 1, 0, 0);
    step("t3a_end", 41'h7, 38, 0, 1, 0);
    cond = 2'b01; start = 1; step("t3b_start", 0, 0, 1, 0, 0);
    step("t3b_word0", 41'h6, 5, 1, 0, 0);
    step("t3b_branch_fall", 41'h5, 6, 1, 0, 0);
    step("t3b_end", 41'h8, 6, 0, 1, 0);
    wr(0, 0, mw(41'h9, JMP, 0, 0, 63), 6, 1);
    wr(0, 63, mw(41'ha, BRA, 1, 0, 38), 6, 1);
    start = 1; step("t3c_start", 0, 0, 1, 0, 0);
    step("t3c_word0", 41'h9, 63, 1, 0, 0);
    step("t3c_wrap", 41'ha, 0, 1, 0, 0);
    halt_req = 1; step("t3c_halt_req", 0, 0, 0, 1, 0);
    halt_req = 0; step("t3c_halted", 0, 0, 0, 1, 0);

    // T4: stall freezes three cycles, then halt_req beats stall
    wr(0, 0, mw(41'hb, JMP, 0, 0, 1), 0, 1);
    wr(0, 1, mw(41'hc, JMP, 0, 0, 2), 0, 1);
    wr(0, 2, mw(41'hd, ENDS, 0, 0, 0), 0, 1);
    start = 1; step("t4_start", 0, 0, 1, 0, 0);
    step("t4_word0", 41'hb, 1, 1, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) step("t4_stall_hold", 41'hb, 1, 1, 0, 0);
    stall = 0; step("t4_resume_word1", 41'hc, 2, 1, 0, 0);
    step("t4_end", 41'hd, 2, 0, 1, 0);
    step("t4_halted", 0, 2, 0, 1, 0);
    start = 1; step("t4b_start", 0, 0, 1, 0, 0);
    step("t4b_word0", 41'hb, 1, 1, 0, 0);
    stall = 1; halt_req = 1; step("t4b_halt_over_stall", 0, 1, 0, 1, 0);
    stall = 0; start = 1; step("t4b_halt_over_start", 0, 1, 0, 1, 0);
    halt_req = 0;

    // T5: write while busy dropped, async reset mid-run, identical rerun
    start = 1; step("t5_start", 0, 0, 1, 0, 0);
    wr_en = 1; wr_sel = 0; wr_addr = 1; wr_data = mw(41'h63, ENDS, 0, 0, 0);
    step("t5_write_in_run", 41'hb, 1, 1, 0, 1);
    step("t5_word1_unchanged", 41'hc, 2, 1, 0, 0);
    step("t5_end", 41'hd, 2, 0, 1, 0);
    start = 1; step("t5b_start", 0, 0, 1, 0, 0);
    step("t5b_word0", 41'hb, 1, 1, 0, 0);
    rst_step("t5_async_reset");
    reset_n = 1'b1; step("t5_reset_release", 0, 0, 0, 0, 0);
    start = 1; step("t5c_start", 0, 0, 1, 0, 0);
    start = 1; step("t5c_start_ignored_in_run", 41'hb, 1, 1, 0, 0);
    step("t5c_word1", 41'hc, 2, 1, 0, 0);
    step("t5c_end", 41'hd, 2, 0, 1, 0);
    step("t5c_halted", 0, 2, 0, 1, 0);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
